// File: rtl/led_pkg.sv
// Shared constants, level type and the fade-ramp step helper for led_pwm_fader.
package led_pkg;

  localparam int NUM_LEDS_DEF = 8;
  localparam int PWM_BITS_DEF = 8;
  localparam int FADE_DIV_DEF = 1024;

  typedef logic [PWM_BITS_DEF-1:0] level_t;

  // Width-agnostic so channels of any PWM_BITS can share it; never steps past target.
  function automatic int unsigned step_toward(int unsigned level, int unsigned target);
    if (level < target) begin
      return level + 1;
    end else if (level > target) begin
      return level - 1;
    end
    return level;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: fade ramp toward its target level and period-aligned PWM compare.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pat_bit,
  input  logic [PWM_BITS-1:0] cap,
  input  logic                fen,
  input  logic                fade_tick,
  input  logic                period_end,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] level_next_d, level_next_q;
  logic [PWM_BITS-1:0] level_act_d, level_act_q;
  logic                led_d, led_q;

  always_comb begin
    target       = pat_bit ? cap : '0;
    level_next_d = level_next_q;
    if (!fen) begin
      level_next_d = target;
    end else if (fade_tick) begin
      level_next_d = PWM_BITS'(step_toward(32'(level_next_q), 32'(target)));
    end
    // Duty only changes at the period boundary so a running PWM cycle is never cut short.
    level_act_d = period_end ? level_next_q : level_act_q;
    led_d       = (pwm_cnt < level_act_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_next_q <= '0;
      level_act_q  <= '0;
      led_q        <= 1'b0;
    end else begin
      level_next_q <= level_next_d;
      level_act_q  <= level_act_d;
      led_q        <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pwm_fader.sv
// PWM dimming stage between the lightshow pattern and the LED pins, with an optional
// linear fade ramp and a global brightness cap.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int FADE_DIV = FADE_DIV_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic [PWM_BITS-1:0] max_level,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                period_strobe
);

  // The PWM period is MAXV cycles, so the counter's last value is MAXV-1.
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam int                  PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_DIV - 1);

  logic [NUM_LEDS-1:0] pat_d, pat_q;
  logic [PWM_BITS-1:0] cap_d, cap_q;
  logic                fen_d, fen_q;
  logic [PWM_BITS-1:0] pwm_cnt_d, pwm_cnt_q;
  logic [PRE_W-1:0]    pre_d, pre_q;
  logic                period_strobe_d, period_strobe_q;
  logic                period_end;
  logic                fade_tick;

  always_comb begin
    pat_d           = pattern_in;
    cap_d           = max_level;
    fen_d           = fade_en;
    period_end      = (pwm_cnt_q == PWM_LAST);
    fade_tick       = (pre_q == PRE_LAST);
    pwm_cnt_d       = period_end ? '0 : pwm_cnt_q + PWM_BITS'(1);
    pre_d           = fade_tick ? '0 : pre_q + PRE_W'(1);
    period_strobe_d = (pwm_cnt_d == PWM_LAST);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pat_q           <= '0;
      cap_q           <= '0;
      fen_q           <= 1'b0;
      pwm_cnt_q       <= '0;
      pre_q           <= '0;
      period_strobe_q <= 1'b0;
    end else begin
      pat_q           <= pat_d;
      cap_q           <= cap_d;
      fen_q           <= fen_d;
      pwm_cnt_q       <= pwm_cnt_d;
      pre_q           <= pre_d;
      period_strobe_q <= period_strobe_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .pat_bit   (pat_q[i]),
      .cap       (cap_q),
      .fen       (fen_q),
      .fade_tick (fade_tick),
      .period_end(period_end),
      .pwm_cnt   (pwm_cnt_q),
      .led       (led_out[i])
    );
  end

  assign period_strobe = period_strobe_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: directed scenarios plus random segments against a behavioural model.
module tb_led_pwm_fader;

  localparam int NL   = 8;
  localparam int PB   = 8;
  localparam int FD   = 4;
  localparam int MAXV = 255;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NL-1:0] pattern_in = '0;
  logic [PB-1:0] max_level = '0;
  logic          fade_en = 1'b0;
  logic [NL-1:0] led_out;
  logic          period_strobe;

  int n_chk = 0;
  int n_fail = 0;
  bit mdl_chk_en = 1'b0;

  led_pwm_fader #(
    .NUM_LEDS(NL),
    .PWM_BITS(PB),
    .FADE_DIV(FD)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pattern_in   (pattern_in),
    .max_level    (max_level),
    .fade_en      (fade_en),
    .led_out      (led_out),
    .period_strobe(period_strobe)
  );

  wire [PB-1:0] lvl7 = dut.g_ch[7].u_ch.level_next_q;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: cycle index since reset drives the PWM phase and fade ticks.
  int          m_cyc;
  int          m_cap;
  logic [NL-1:0] m_pat;
  bit          m_fen;
  int          m_next[NL];
  int          m_act[NL];
  logic [NL-1:0] m_led;
  bit          m_strobe;

  task automatic model_clear();
    m_cyc = 0; m_cap = 0; m_pat = '0; m_fen = 0; m_led = '0; m_strobe = 0;
    for (int i = 0; i < NL; i++) begin
      m_next[i] = 0;
      m_act[i]  = 0;
    end
  endtask

  task automatic model_step();
    int phase, tgt;
    bit tick;
    phase = m_cyc % MAXV;
    tick  = ((m_cyc % FD) == FD - 1);
    for (int i = 0; i < NL; i++) begin
      tgt = m_pat[i] ? m_cap : 0;
      m_led[i] = (phase < m_act[i]);
      if (phase == MAXV - 1) m_act[i] = m_next[i];
      if (!m_fen) m_next[i] = tgt;
      else if (tick) m_next[i] = m_next[i] + int'(tgt > m_next[i]) - int'(tgt < m_next[i]);
    end
    m_cyc++;
    m_strobe = ((m_cyc % MAXV) == MAXV - 1);
    m_pat = pattern_in;
    m_cap = int'(max_level);
    m_fen = fade_en;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_clear();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mdl_chk_en) begin
        check("model_led", led_out, m_led);
        check("model_strobe", period_strobe, m_strobe);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_strobe(input int bound);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!period_strobe && n < bound);
    if (!period_strobe) check("strobe_timeout", period_strobe, 1);
  endtask

  task automatic wait_level(input string tag, input int lvl, input int bound);
    int n;
    n = 0;
    while (int'(lvl7) < lvl && n < bound) begin
      @(posedge clk); #1; n++;
    end
    if (int'(lvl7) < lvl) check(tag, lvl7, lvl);
  endtask

  initial begin
    int n, hi, prev, bad, other, first, maxstep, d;
    int bit_hi[NL];

    // Reset held with everything asking for full brightness.
    pattern_in = 8'hFF; max_level = 8'd255; fade_en = 1'b0; resetn = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_led", led_out, 0);
      check("rst_strobe", period_strobe, 0);
    end
    mdl_chk_en = 1'b1;
    resetn = 1'b1;

    // The release cycle holds pwm_cnt=0; the strobe lands in the 255th cycle.
    n = 1;
    do begin
      @(posedge clk); #1; n++;
    end while (!period_strobe && n < 400);
    check("first_strobe_cycle", n, 255);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!period_strobe && n < 400);
      check("strobe_spacing", n, MAXV);
    end

    // Immediate on for channel 0 only.
    @(negedge clk); pattern_in = 8'h00;
    wait_strobe(300); wait_strobe(300);
    @(negedge clk); pattern_in = 8'h01;
    n = 0;
    while (!led_out[0] && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("on_latency_le_258", (n <= 258), 1);
    hi = 0; other = 0;
    for (int k = 0; k < MAXV; k++) begin
      @(posedge clk); #1;
      hi += int'(led_out[0]);
      other |= int'(led_out[7:1]);
    end
    check("on_constant", hi, MAXV);
    check("on_others_off", other, 0);

    // Duty accuracy at level 64, all channels.
    @(negedge clk); max_level = 8'd64; pattern_in = 8'hFF;
    wait_strobe(300); wait_strobe(300); wait_strobe(300);
    bad = 0;
    for (int i = 0; i < NL; i++) bit_hi[i] = 0;
    for (int k = 0; k < MAXV; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NL; i++) begin
        bit_hi[i] += int'(led_out[i]);
        if (led_out[i] !== (((k + MAXV - 1) % MAXV) < 64)) bad++;
      end
    end
    for (int i = 0; i < NL; i++) check($sformatf("duty64_ch%0d", i), bit_hi[i], 64);
    check("duty64_align", bad, 0);

    // Cap to zero: dark from the next boundary.
    @(negedge clk); max_level = 8'd0;
    repeat (3) @(posedge clk);
    wait_strobe(300);
    other = 0;
    for (int k = 0; k < MAXV; k++) begin
      @(posedge clk); #1;
      other |= int'(led_out);
    end
    check("cap0_dark", other, 0);

    // Fade ramp up on channel 7.
    @(negedge clk); pattern_in = 8'h00; fade_en = 1'b1; max_level = 8'd255;
    repeat (5) @(posedge clk);
    @(negedge clk); pattern_in = 8'h80;
    n = 0; hi = 0; prev = 0; bad = 0;
    while (lvl7 != 8'd255 && n < 1300) begin
      @(posedge clk); #1; n++;
      hi += int'(led_out[7]);
      if (period_strobe) begin
        if (hi < prev) bad++;
        prev = hi; hi = 0;
      end
    end
    check("fade_time_1020pm4", (n >= 1016 && n <= 1024), 1);
    check("fade_monotonic", bad, 0);
    wait_strobe(300); wait_strobe(300);
    hi = 0;
    for (int k = 0; k < MAXV; k++) begin
      @(posedge clk); #1;
      hi += int'(led_out[7]);
    end
    check("fade_full_duty", hi, MAXV);

    // Dropping fade_en snaps to the target.
    @(negedge clk); fade_en = 1'b0; pattern_in = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    check("snap_off", lvl7, 0);

    // Mid-ramp reversal from about 100.
    @(negedge clk); fade_en = 1'b1; pattern_in = 8'h80;
    wait_level("rev_reach_100", 100, 600);
    @(negedge clk); pattern_in = 8'h00;
    first = int'(lvl7); prev = first; maxstep = 0; n = 0;
    while (lvl7 != 0 && n < 600) begin
      @(posedge clk); #1; n++;
      d = int'(lvl7) - prev;
      if (d < 0) d = -d;
      if (d > maxstep) maxstep = d;
      prev = int'(lvl7);
    end
    check("rev_start_near_100", (first >= 99 && first <= 102), 1);
    check("rev_no_jump", (maxstep <= 1), 1);
    check("rev_end_zero", lvl7, 0);
    repeat (20) @(posedge clk);
    #1 check("rev_hold_zero", lvl7, 0);

    // Asynchronous reset in the middle of a fade.
    @(negedge clk); pattern_in = 8'h80;
    wait_level("rst_fade_reach_60", 60, 400);
    wait_strobe(300);
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("async_rst_led", led_out, 0);
    check("async_rst_strobe", period_strobe, 0);
    check("async_rst_level", lvl7, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("restart_from_zero", (lvl7 <= 8'd2), 1);

    // Random segments checked cycle by cycle against the model.
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      pattern_in = NL'($urandom);
      max_level  = PB'($urandom_range(0, 255));
      fade_en    = 1'($urandom_range(0, 1));
      repeat ($urandom_range(30, 600)) @(posedge clk);
    end

    @(negedge clk);
    mdl_chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
